// File: rtl/alu_result_buffer.sv
// alu_result_buffer
// -----------------
// Sits after the ALU. It captures every result the ALU presents, holds it in a
// small FIFO and hands it to a consumer. The ALU cannot be stalled, so a result
// that arrives while the FIFO is full, with no pop in the same cycle, is
// discarded.
//
// Optional feature: define ALU_RESULT_BUF_STATS_EN to build the saturating drop
// and carry counters. When the macro is undefined, drop_cnt and carry_cnt are
// tied to zero. The port list is the same in both builds.
//
// Parameters
//   WIDTH  ALU operand width. Results are WIDTH+1 bits; bit WIDTH is the carry.
//   DEPTH  Number of FIFO entries. Must be a power of two, 2 or greater.
//   LVL_W  Width of the occupancy output.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous, active-high reset
//   res_in         in   ALU result (WIDTH+1 bits)
//   res_in_valid   in   res_in is valid in this cycle
//   res_out        out  head-of-FIFO result; 0 while empty
//   res_out_valid  out  FIFO is non-empty
//   res_out_ready  in   consumer takes the head entry
//   level          out  occupied entries, 0..DEPTH
//   full / empty   out  level == DEPTH / level == 0
//   drop_cnt       out  results discarded while full (saturating)
//   carry_cnt      out  accepted results with the carry bit set (saturating)
//
// Handshake
//   A pop happens on a rising edge where res_out_valid && res_out_ready.
//   The input side has no ready signal. A push happens when res_in_valid is
//   high and the FIFO is not full, or when a pop frees a slot in the same
//   cycle. Otherwise a valid result is dropped. All outputs come from
//   registers, so there is no combinational path from any input to any output.
module alu_result_buffer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   res_in,
  input  logic             res_in_valid,
  output logic [WIDTH:0]   res_out,
  output logic             res_out_valid,
  input  logic             res_out_ready,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      carry_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  // Storage is not reset; only the pointers and occupancy define what is valid.
  logic [WIDTH:0]   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  // While empty, res_out_ready has no effect.
  assign w_pop   = !w_empty && res_out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
  assign w_push  = res_in_valid && (!w_full || w_pop);
  assign w_drop  = res_in_valid && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= res_in;
    end
  end

  // Each pointer is PTR_W bits wide and DEPTH is a power of two, so the
  // pointers wrap from DEPTH-1 to 0 on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  assign res_out       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign res_out_valid = !w_empty;
  assign level         = r_level;
  assign full          = w_full;
  assign empty         = w_empty;

`ifdef ALU_RESULT_BUF_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [15:0] r_carry_cnt;

  // Both counters stop at 16'hFFFF instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt  <= '0;
      r_carry_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      // Only accepted results count; dropped results never reach carry_cnt.
      if (w_push && res_in[WIDTH] && (r_carry_cnt != 16'hFFFF)) begin
        r_carry_cnt <= r_carry_cnt + 16'd1;
      end
    end
  end

  assign drop_cnt  = r_drop_cnt;
  assign carry_cnt = r_carry_cnt;
`else
  assign drop_cnt  = 16'h0000;
  assign carry_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed testbench for alu_result_buffer with WIDTH=6 and DEPTH=4.
// The expected counter values follow whether ALU_RESULT_BUF_STATS_EN is
// defined for this build.
module tb_alu_result_buffer;

  localparam int WIDTH = 6;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

`ifdef ALU_RESULT_BUF_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [WIDTH:0]   res_in = '0;
  logic             res_in_valid = 1'b0;
  logic [WIDTH:0]   res_out;
  logic             res_out_valid;
  logic             res_out_ready = 1'b0;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic [15:0]      drop_cnt;
  logic [15:0]      carry_cnt;

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .res_in(res_in), .res_in_valid(res_in_valid),
    .res_out(res_out), .res_out_valid(res_out_valid), .res_out_ready(res_out_ready),
    .level(level), .full(full), .empty(empty),
    .drop_cnt(drop_cnt), .carry_cnt(carry_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] exp_v;

  // ---------------- driver tasks ----------------
  // Inputs are set 1 ns after a rising edge. Outputs are sampled 1 ns after the
  // next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH:0] d, input logic rdy);
    res_in_valid  = v;
    res_in        = d;
    res_out_ready = rdy;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    step();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
    n_vec++; if (res_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", res_out_valid); end
    n_vec++; if (res_out !== 7'h00) begin n_err++; $display("FAIL reset_res_out got %h want 00", res_out); end
    n_vec++; if (drop_cnt !== 16'h0 || carry_cnt !== 16'h0) begin n_err++; $display("FAIL reset_counters got %h/%h want 0/0", drop_cnt, carry_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    drive(1'b1, 7'h45, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    n_vec++; if (res_out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", res_out_valid); end
    n_vec++; if (res_out !== 7'h45) begin n_err++; $display("FAIL single_data got %h want 45", res_out); end
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL single_level got %0d want 1", level); end
    n_vec++; if (carry_cnt !== 16'(STATS)) begin n_err++; $display("FAIL single_carry got %0d want %0d", carry_cnt, STATS); end
    // The consumer is not ready, so the entry must stay at the head.
    step();
    n_vec++; if (res_out !== 7'h45 || level !== 3'd1) begin n_err++; $display("FAIL single_hold got %h/%0d want 45/1", res_out, level); end
    drive(1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    n_vec++; if (empty !== 1'b1 || res_out !== 7'h00) begin n_err++; $display("FAIL single_pop got empty=%b out=%h want 1/00", empty, res_out); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 7'(i), 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0);
    n_vec++; if (full !== 1'b1 || level !== 3'd4) begin n_err++; $display("FAIL fill_full got full=%b level=%0d want 1/4", full, level); end
    n_vec++; if (drop_cnt !== 16'(STATS)) begin n_err++; $display("FAIL fill_drop got %0d want %0d", drop_cnt, STATS); end
    n_vec++; if (carry_cnt !== 16'(STATS)) begin n_err++; $display("FAIL fill_carry got %0d want %0d", carry_cnt, STATS); end
    for (int i = 1; i <= 4; i++) begin
      n_vec++; if (res_out !== 7'(i)) begin n_err++; $display("FAIL fill_drain got %h want %h", res_out, 7'(i)); end
      drive(1'b0, '0, 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b0);
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_empty got %b want 1", empty); end
  endtask

  task automatic test_full_concurrent();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'h11 + 7'(i), 1'b0);
      step();
    end
    // Push and pop in the same cycle while full: 7F is accepted and 11 leaves.
    drive(1'b1, 7'h7F, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    n_vec++; if (level !== 3'd4 || full !== 1'b1) begin n_err++; $display("FAIL conc_level got %0d/%b want 4/1", level, full); end
    n_vec++; if (drop_cnt !== 16'(STATS)) begin n_err++; $display("FAIL conc_drop got %0d want %0d", drop_cnt, STATS); end
    n_vec++; if (carry_cnt !== 16'(2 * STATS)) begin n_err++; $display("FAIL conc_carry got %0d want %0d", carry_cnt, 2 * STATS); end
    exp_q = '{7'h12, 7'h13, 7'h14, 7'h7F};
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      n_vec++; if (res_out !== exp_v) begin n_err++; $display("FAIL conc_drain got %h want %h", res_out, exp_v); end
      drive(1'b0, '0, 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b0);
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL conc_empty got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 7'h20 + 7'(i), 1'b1);
      exp_q.push_back(7'h20 + 7'(i));
      step();
      exp_v = exp_q.pop_front();
      n_vec++; if (res_out_valid !== 1'b1 || res_out !== exp_v) begin n_err++; $display("FAIL wrap_data got %b/%h want 1/%h", res_out_valid, res_out, exp_v); end
      n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL wrap_level got %0d want 1", level); end
    end
    drive(1'b0, '0, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    n_vec++; if (empty !== 1'b1 || drop_cnt !== 16'(STATS)) begin n_err++; $display("FAIL wrap_end got empty=%b drop=%0d want 1/%0d", empty, drop_cnt, STATS); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'h30 + 7'(i), 1'b0);
      step();
    end
    drive(1'b1, 7'h7E, 1'b0);
    for (int i = 0; i < 70000; i++) step();
    drive(1'b0, '0, 1'b0);
    n_vec++; if (drop_cnt !== (STATS != 0 ? 16'hFFFF : 16'h0000)) begin n_err++; $display("FAIL sat_drop got %h want %h", drop_cnt, (STATS != 0 ? 16'hFFFF : 16'h0000)); end
    n_vec++; if (carry_cnt !== 16'(2 * STATS)) begin n_err++; $display("FAIL sat_carry got %0d want %0d", carry_cnt, 2 * STATS); end
    n_vec++; if (res_out !== 7'h30 || level !== 3'd4) begin n_err++; $display("FAIL sat_contents got %h/%0d want 30/4", res_out, level); end
  endtask

  task automatic test_async_reset();
    // Assert reset away from any clock edge; the outputs must clear at once.
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (res_out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL areset_flags got v=%b e=%b f=%b want 0/1/0", res_out_valid, empty, full); end
    n_vec++; if (level !== 3'd0 || res_out !== 7'h00) begin n_err++; $display("FAIL areset_level got %0d/%h want 0/00", level, res_out); end
    n_vec++; if (drop_cnt !== 16'h0 || carry_cnt !== 16'h0) begin n_err++; $display("FAIL areset_counters got %h/%h want 0/0", drop_cnt, carry_cnt); end
    step();
    rst = 1'b0;
    drive(1'b1, 7'h55, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    n_vec++; if (res_out !== 7'h55 || level !== 3'd1) begin n_err++; $display("FAIL areset_push got %h/%0d want 55/1", res_out, level); end
    n_vec++; if (carry_cnt !== 16'(STATS) || drop_cnt !== 16'h0) begin n_err++; $display("FAIL areset_stats got %0d/%0d want %0d/0", carry_cnt, drop_cnt, STATS); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_concurrent();
    test_wrap();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
